i2s_stream_controller: RTL and testbench

Parametrised sample sequencer in the i2s_clock domain, between the read side of a ping-pong FIFO and the I2S serialiser. Delivers one sample per serialiser request for 1..8 channels with configurable sample width, and can source FIFO data, an internal ramp test tone, or silence. Handles FIFO underrun without stalling the serialiser and reports underruns and frame-sync errors.

---
 rtl/i2s_stream_pkg.sv | 25 ++
 rtl/i2s_stream_controller_if.sv | 38 +++
 rtl/i2s_ramp_gen.sv | 23 ++
 rtl/i2s_stream_controller.sv | 153 +++++++++++++++
 tb/tb_i2s_stream_controller.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2s_stream_pkg.sv
// Shared encodings and helpers for the I2S sample sequencer.
package i2s_stream_pkg;

  typedef enum logic [1:0] {
    MODE_FIFO = 2'd0,
    MODE_TONE = 2'd1,
    MODE_MUTE = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SYNTH  = 2'd3
  } state_e;

  localparam int FRAME_START_BIT = 31;
  localparam int CNT_W           = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/i2s_stream_controller_if.sv
// Control, FIFO read side and serialiser side of the sample sequencer.
interface i2s_stream_controller_if
  import i2s_stream_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int COUNT_WIDTH  = 24
);
  logic                    enable;
  logic [1:0]              mode;
  logic [SAMPLE_WIDTH-1:0] tone_step;
  logic                    clear_status;
  logic                    read_ready;
  logic                    read_activate;
  logic [COUNT_WIDTH-1:0]  read_size;
  logic [31:0]             read_data;
  logic                    read_strobe;
  logic                    audio_data_request;
  logic                    audio_data_ack;
  logic [SAMPLE_WIDTH-1:0] audio_data;
  logic [2:0]              audio_channel;
  logic                    underrun;
  logic [CNT_W-1:0]        underrun_count;
  logic [CNT_W-1:0]        sync_err_count;

  modport master (
    input  enable, mode, tone_step, clear_status, read_ready, read_size, read_data,
           audio_data_request,
    output read_activate, read_strobe, audio_data_ack, audio_data, audio_channel,
           underrun, underrun_count, sync_err_count
  );

  modport slave (
    output enable, mode, tone_step, clear_status, read_ready, read_size, read_data,
           audio_data_request,
    input  read_activate, read_strobe, audio_data_ack, audio_data, audio_channel,
           underrun, underrun_count, sync_err_count
  );
endinterface

// File: rtl/i2s_ramp_gen.sv
// Wrapping ramp accumulator used as the test-tone source.
module i2s_ramp_gen
  import i2s_stream_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             i2s_clock,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] acc_o
);
  logic [WIDTH-1:0] acc_q;

  always_ff @(posedge i2s_clock or posedge rst) begin
    if (rst)            acc_q <= '0;
    else if (clear_i)   acc_q <= '0;
    else if (advance_i) acc_q <= acc_q + step_i;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/i2s_stream_controller.sv
// Sample sequencer between a ping-pong FIFO read port and the I2S serialiser.
module i2s_stream_controller
  import i2s_stream_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int CHANNELS     = 2,
  parameter int COUNT_WIDTH  = 24
) (
  input logic                     rst,
  input logic                     i2s_clock,
  i2s_stream_controller_if.master bus
);
  localparam logic [2:0] LAST_CH = 3'(CHANNELS - 1);

  state_e                  state_q, state_d;
  mode_e                   fmode_q, fmode_d, mode_raw, mode_nxt;
  logic [2:0]              ch_q, ch_d, ach_q, ach_d, dch, ch_inc;
  logic                    ack_q, ack_d, strobe_q, strobe_d, underrun_q, underrun_d;
  logic [SAMPLE_WIDTH-1:0] data_q, data_d, tone_acc;
  logic [COUNT_WIDTH-1:0]  rcnt_q, rcnt_d;
  logic [CNT_W-1:0]        ucnt_q, ucnt_d, scnt_q, scnt_d;
  logic                    want_fifo, word_avail, take, frame_bit, ramp_adv, ramp_clr;

  // A mode change only lands on a frame boundary, so the next sample's mode
  // is the live input at channel 0 and the latched frame mode otherwise.
  assign mode_raw   = mode_e'(bus.mode);
  assign mode_nxt   = (ch_q == 3'd0) ? mode_raw : fmode_q;
  assign want_fifo  = (mode_raw == MODE_FIFO) || (mode_nxt == MODE_FIFO);
  assign word_avail = (state_q == ST_ACTIVE) && (rcnt_q < bus.read_size);
  assign take       = bus.enable && (state_q != ST_IDLE) && bus.audio_data_request && !ack_q;
  assign frame_bit  = bus.read_data[FRAME_START_BIT];
  assign ch_inc     = (ch_q == LAST_CH) ? 3'd0 : ch_q + 3'd1;

  i2s_ramp_gen #(.WIDTH(SAMPLE_WIDTH)) u_ramp (
    .i2s_clock (i2s_clock),
    .rst       (rst),
    .clear_i   (ramp_clr),
    .advance_i (ramp_adv),
    .step_i    (bus.tone_step),
    .acc_o     (tone_acc)
  );

  always_comb begin
    state_d    = state_q;
    fmode_d    = fmode_q;
    ch_d       = ch_q;
    ach_d      = ach_q;
    ack_d      = ack_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q;
    data_d     = data_q;
    rcnt_d     = rcnt_q;
    ucnt_d     = ucnt_q;
    scnt_d     = scnt_q;
    dch        = ch_q;
    ramp_adv   = 1'b0;
    ramp_clr   = 1'b0;

    if (ack_q && !bus.audio_data_request) ack_d = 1'b0;

    if (!bus.enable) begin
      state_d  = ST_IDLE;
      ch_d     = '0;
      rcnt_d   = '0;
      ramp_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_ARM;
        ST_ARM: begin
          rcnt_d = '0;
          if (want_fifo && bus.read_ready) state_d = ST_ACTIVE;
          else if (!want_fifo)             state_d = ST_SYNTH;
        end
        ST_ACTIVE: if (rcnt_q == bus.read_size) state_d = ST_ARM;
        ST_SYNTH:  if (want_fifo) state_d = ST_ARM;
        default:   state_d = ST_IDLE;
      endcase
    end

    if (take) begin
      ack_d   = 1'b1;
      fmode_d = mode_nxt;
      data_d  = '0;
      case (mode_nxt)
        MODE_FIFO: begin
          if (word_avail) begin
            data_d   = bus.read_data[SAMPLE_WIDTH-1:0];
            strobe_d = 1'b1;
            rcnt_d   = rcnt_q + COUNT_WIDTH'(1);
            // Frame marker disagrees with our position: count it and resync.
            if (frame_bit != (ch_q == 3'd0)) begin
              scnt_d = sat_inc(scnt_q);
              dch    = frame_bit ? 3'd0 : ch_inc;
            end
          end else begin
            underrun_d = 1'b1;
            ucnt_d     = sat_inc(ucnt_q);
          end
        end
        MODE_TONE: begin
          data_d   = tone_acc;
          ramp_adv = (ch_q == LAST_CH);
        end
        default: ;
      endcase
      ach_d = dch;
      ch_d  = (dch == LAST_CH) ? 3'd0 : dch + 3'd1;
    end

    if (bus.clear_status) begin
      underrun_d = 1'b0;
      ucnt_d     = '0;
      scnt_d     = '0;
    end
  end

  always_ff @(posedge i2s_clock or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fmode_q    <= MODE_FIFO;
      ch_q       <= '0;
      ach_q      <= '0;
      ack_q      <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      data_q     <= '0;
      rcnt_q     <= '0;
      ucnt_q     <= '0;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      fmode_q    <= fmode_d;
      ch_q       <= ch_d;
      ach_q      <= ach_d;
      ack_q      <= ack_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      data_q     <= data_d;
      rcnt_q     <= rcnt_d;
      ucnt_q     <= ucnt_d;
      scnt_q     <= scnt_d;
    end
  end

  assign bus.read_activate  = (state_q == ST_ACTIVE);
  assign bus.read_strobe    = strobe_q;
  assign bus.audio_data_ack = ack_q;
  assign bus.audio_data     = data_q;
  assign bus.audio_channel  = ach_q;
  assign bus.underrun       = underrun_q;
  assign bus.underrun_count = ucnt_q;
  assign bus.sync_err_count = scnt_q;
endmodule

// File: tb/tb_i2s_stream_controller.sv
// Scoreboard bench: a frame-level model predicts each sample; a monitor checks acks.
module tb_i2s_stream_controller;
  import i2s_stream_pkg::*;

  localparam int SW = 16;
  localparam int CH = 2;
  localparam int CW = 24;

  logic i2s_clock = 1'b0;
  logic rst;
  always #5 i2s_clock = ~i2s_clock;

  i2s_stream_controller_if #(.SAMPLE_WIDTH(SW), .COUNT_WIDTH(CW)) bus ();

  i2s_stream_controller #(.SAMPLE_WIDTH(SW), .CHANNELS(CH), .COUNT_WIDTH(CW)) dut (
    .rst       (rst),
    .i2s_clock (i2s_clock),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [SW-1:0] data;
    logic [2:0]    ch;
    logic          strobe;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model state
  int            m_ch, m_fmode, m_ucnt, m_scnt;
  bit            m_uflag;
  logic [SW-1:0] m_acc;
  logic [31:0]   m_words[$];

  // FIFO-side model: flat word store plus block lengths
  logic [31:0] fifo_words[$];
  int          fifo_lens[$];
  int          fidx = 0;
  logic        act_prev = 1'b0;
  logic        ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  always @(negedge i2s_clock) begin
    if (bus.read_strobe) fidx++;
    if (act_prev && !bus.read_activate && fifo_lens.size() > 0) begin
      for (int i = 0; i < fifo_lens[0]; i++) void'(fifo_words.pop_front());
      void'(fifo_lens.pop_front());
      fidx = 0;
    end
    if (!act_prev && bus.read_activate) fidx = 0;
    act_prev = bus.read_activate;
    bus.read_ready = (fifo_lens.size() > 0);
    bus.read_size  = (fifo_lens.size() > 0) ? CW'(fifo_lens[0]) : '0;
    bus.read_data  = (fifo_lens.size() > 0 && fidx < fifo_lens[0]) ? fifo_words[fidx] : 32'h0;
  end

  always @(negedge i2s_clock) begin
    if (bus.audio_data_ack && !ack_prev) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_ack: got ack with data %0h, expected none", bus.audio_data);
      end else begin
        mon_e = sb.pop_front();
        check("sample_data", 32'(bus.audio_data), 32'(mon_e.data));
        check("sample_chan", 32'(bus.audio_channel), 32'(mon_e.ch));
        check("sample_strobe", 32'(bus.read_strobe), 32'(mon_e.strobe));
      end
    end else if (bus.read_strobe) begin
      total++; bad++;
      $display("FAIL stray_strobe: got strobe 1 without new ack, expected 0");
    end
    ack_prev = bus.audio_data_ack;
  end

  task automatic push_word(input logic [31:0] w);
    fifo_words.push_back(w);
    m_words.push_back(w);
  endtask

  task automatic close_block(input int n);
    fifo_lens.push_back(n);
  endtask

  task automatic model_push();
    exp_t        e;
    int          eff, dch;
    logic [31:0] w;
    eff      = (m_ch == 0) ? int'(bus.mode) : m_fmode;
    m_fmode  = eff;
    dch      = m_ch;
    e.data   = '0;
    e.strobe = 1'b0;
    if (eff == 0) begin
      if (m_words.size() > 0) begin
        w        = m_words.pop_front();
        e.data   = w[SW-1:0];
        e.strobe = 1'b1;
        if (w[31] != (m_ch == 0)) begin
          m_scnt = sat16(m_scnt);
          dch    = w[31] ? 0 : (m_ch + 1) % CH;
        end
      end else begin
        m_uflag = 1'b1;
        m_ucnt  = sat16(m_ucnt);
      end
    end else if (eff == 1) begin
      e.data = m_acc;
      if (dch == CH - 1) m_acc = m_acc + bus.tone_step;
    end
    e.ch = 3'(dch);
    m_ch = (dch + 1) % CH;
    sb.push_back(e);
  endtask

  task automatic request();
    int n;
    model_push();
    bus.audio_data_request = 1'b1;
    @(negedge i2s_clock);
    check("ack_latency", 32'(bus.audio_data_ack), 32'd1);
    n = 0;
    while (!bus.audio_data_ack && n < 8) begin @(negedge i2s_clock); n++; end
    bus.audio_data_request = 1'b0;
    @(negedge i2s_clock);
    n = 0;
    while (bus.audio_data_ack && n < 8) begin @(negedge i2s_clock); n++; end
    check("ack_release", 32'(bus.audio_data_ack), 32'd0);
    repeat (3) @(negedge i2s_clock);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_underrun"}, 32'(bus.underrun), 32'(m_uflag));
    check({tag, "_ucnt"}, 32'(bus.underrun_count), 32'(m_ucnt));
    check({tag, "_scnt"}, 32'(bus.sync_err_count), 32'(m_scnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, 32'(bus.audio_data_ack), 32'd0);
    check({tag, "_act"}, 32'(bus.read_activate), 32'd0);
    check({tag, "_strobe"}, 32'(bus.read_strobe), 32'd0);
    check({tag, "_data"}, 32'(bus.audio_data), 32'd0);
    check({tag, "_chan"}, 32'(bus.audio_channel), 32'd0);
    check({tag, "_underrun"}, 32'(bus.underrun), 32'd0);
    check({tag, "_ucnt"}, 32'(bus.underrun_count), 32'd0);
    check({tag, "_scnt"}, 32'(bus.sync_err_count), 32'd0);
  endtask

  task automatic clear_pulse();
    bus.clear_status = 1'b1;
    @(negedge i2s_clock);
    bus.clear_status = 1'b0;
    m_uflag = 1'b0; m_ucnt = 0; m_scnt = 0;
    @(negedge i2s_clock);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int g, r, n;
    logic [31:0] blk[4];
    rst = 1'b1;
    bus.enable = 1'b0; bus.mode = 2'd0; bus.tone_step = '0;
    bus.clear_status = 1'b0; bus.audio_data_request = 1'b0;
    m_ch = 0; m_fmode = 0; m_ucnt = 0; m_scnt = 0; m_uflag = 1'b0; m_acc = '0;
    repeat (3) @(negedge i2s_clock);
    check_zero("reset");
    rst = 1'b0;

    // Well-formed stereo block
    blk[0] = 32'h80000011; blk[1] = 32'h00000022; blk[2] = 32'h80000033; blk[3] = 32'h00000044;
    for (int i = 0; i < 4; i++) push_word(blk[i]);
    close_block(4);
    bus.enable = 1'b1;
    repeat (4) @(negedge i2s_clock);
    for (int i = 0; i < 4; i++) request();
    check_status("block");

    // Underrun with no block available, then clear
    request();
    check_status("underrun1");
    request();
    check_status("underrun2");
    clear_pulse();
    check_status("cleared");

    // Frame-sync error: unmarked word at channel 0
    push_word(32'h00000055); push_word(32'h80000066);
    close_block(2);
    repeat (3) @(negedge i2s_clock);
    request(); request();
    check_status("sync");

    // Ramp tone
    bus.mode = 2'd1; bus.tone_step = SW'(16'h0100);
    repeat (3) @(negedge i2s_clock);
    for (int i = 0; i < 6; i++) request();

    // Randomised traffic
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        n = $urandom_range(0, 5);
        bus.mode = (n > 3) ? 2'd0 : 2'(n);
      end else if (r == 1) begin
        bus.tone_step = SW'($urandom);
      end else if (r <= 4 && m_words.size() < 8) begin
        n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) push_word($urandom);
        close_block(n);
      end else if (r == 5) begin
        clear_pulse();
      end
      repeat (3) @(negedge i2s_clock);
      request();
      if (it % 10 == 9) check_status("random");
    end

    // Drain, then drop enable mid-block
    bus.mode = 2'd0;
    g = 0;
    while (m_words.size() > 0 && g < 60) begin request(); g++; end
    check("drain_left", 32'(m_words.size()), 32'd0);
    blk[0] = 32'h80000001; blk[1] = 32'h00000002; blk[2] = 32'h80000003; blk[3] = 32'h00000004;
    for (int i = 0; i < 4; i++) push_word(blk[i]);
    close_block(4);
    repeat (3) @(negedge i2s_clock);
    request(); request();
    check("pre_drop_act", 32'(bus.read_activate), 32'd1);
    bus.enable = 1'b0;
    @(posedge i2s_clock); #1;
    check("drop_act", 32'(bus.read_activate), 32'd0);
    m_words.delete(); m_ch = 0; m_acc = '0;
    repeat (2) @(negedge i2s_clock);
    bus.enable = 1'b1;
    repeat (3) @(negedge i2s_clock);
    request();
    check_status("reenable");

    // Asynchronous reset while the ack is high
    push_word(32'h800000AA); push_word(32'h000000BB);
    close_block(2);
    repeat (3) @(negedge i2s_clock);
    model_push();
    bus.audio_data_request = 1'b1;
    @(negedge i2s_clock); #1;
    check("pre_rst_ack", 32'(bus.audio_data_ack), 32'd1);
    check("pre_rst_act", 32'(bus.read_activate), 32'd1);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    bus.audio_data_request = 1'b0;
    repeat (2) @(negedge i2s_clock);
    rst = 1'b0;
    repeat (2) @(negedge i2s_clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
